// File: rtl/keymgr_sideload_seq.sv
// Streams a captured sideload key into a consumer's 32-bit key registers, shares outer, words inner.
// Optional KEYMGR_SIDELOAD_WIPE_EN adds a WIPE pass that overwrites the consumer with zeros on revocation.
module keymgr_sideload_seq #(
    parameter int NumRegsKey   = 8,
    parameter int NumSharesKey = 2,
    localparam int ShareW = (NumSharesKey > 1) ? $clog2(NumSharesKey) : 1,
    localparam int IdxW   = (NumRegsKey > 1) ? $clog2(NumRegsKey) : 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         key_valid_i,
    input  logic [NumSharesKey-1:0][NumRegsKey*32-1:0]   key_i,
    output logic                                         wr_valid_o,
    input  logic                                         wr_ready_i,
    output logic [ShareW-1:0]                            wr_share_o,
    output logic [IdxW-1:0]                              wr_idx_o,
    output logic [31:0]                                  wr_data_o,
    output logic                                         key_loaded_o,
    output logic                                         busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2
`ifdef KEYMGR_SIDELOAD_WIPE_EN
        ,
        WIPE   = 2'd3
`endif
    } state_t;

`ifdef KEYMGR_SIDELOAD_WIPE_EN
    localparam state_t ExitState = WIPE;
`else
    localparam state_t ExitState = IDLE;
`endif

    state_t state, next_state;

    logic [31:0]       cap [NumSharesKey][NumRegsKey];
    logic [ShareW-1:0] share_cnt;
    logic [IdxW-1:0]   idx_cnt;
    logic              revoked;

    logic valid, loaded, busy, send_key;
    logic capture, clear_cap, cnt_clear;
    logic transfer, last_beat;

    assign transfer  = valid && wr_ready_i;
    assign last_beat = (share_cnt == ShareW'(NumSharesKey - 1)) && (idx_cnt == IdxW'(NumRegsKey - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A revocation seen in LOAD only lets the beat on the bus finish, then leaves.
    always_comb begin
        next_state = state;
        valid      = 1'b0;
        loaded     = 1'b0;
        busy       = 1'b0;
        send_key   = 1'b0;
        capture    = 1'b0;
        clear_cap  = 1'b0;
        cnt_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid_i) begin
                    capture    = 1'b1;
                    cnt_clear  = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                valid    = 1'b1;
                busy     = 1'b1;
                send_key = 1'b1;
                if (transfer) begin
                    if (revoked || !key_valid_i) begin
                        clear_cap  = 1'b1;
                        cnt_clear  = 1'b1;
                        next_state = ExitState;
                    end else if (last_beat) begin
                        cnt_clear  = 1'b1;
                        next_state = LOADED;
                    end
                end
            end
            LOADED: begin
                loaded = 1'b1;
                if (!key_valid_i) begin
                    clear_cap  = 1'b1;
                    cnt_clear  = 1'b1;
                    next_state = ExitState;
                end
            end
`ifdef KEYMGR_SIDELOAD_WIPE_EN
            WIPE: begin
                valid = 1'b1;
                busy  = 1'b1;
                if (transfer && last_beat) begin
                    cnt_clear  = 1'b1;
                    next_state = IDLE;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            share_cnt <= '0;
            idx_cnt   <= '0;
            revoked   <= 1'b0;
        end else begin
            revoked <= (next_state == LOAD) && (revoked || (state == LOAD && !key_valid_i));
            if (cnt_clear) begin
                share_cnt <= '0;
                idx_cnt   <= '0;
            end else if (transfer) begin
                if (idx_cnt == IdxW'(NumRegsKey - 1)) begin
                    idx_cnt   <= '0;
                    share_cnt <= share_cnt + 1'b1;
                end else begin
                    idx_cnt <= idx_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSharesKey; s++) begin
                for (int i = 0; i < NumRegsKey; i++) begin
                    cap[s][i] <= '0;
                end
            end
        end else if (capture || clear_cap) begin
            for (int s = 0; s < NumSharesKey; s++) begin
                for (int i = 0; i < NumRegsKey; i++) begin
                    cap[s][i] <= capture ? key_i[s][i*32 +: 32] : 32'h0;
                end
            end
        end
    end

    assign wr_valid_o   = valid;
    assign wr_share_o   = share_cnt;
    assign wr_idx_o     = idx_cnt;
    assign wr_data_o    = send_key ? cap[share_cnt][idx_cnt] : 32'h0;
    assign key_loaded_o = loaded;
    assign busy_o       = busy;

endmodule

// File: doc/keymgr_sideload_seq.md
Name: keymgr_sideload_seq

Overview:
- Sequences a sideloaded hardware key from the key manager into a 32-bit register-write port of a consuming crypto block (AES/KMAC key registers).
- Captures the multi-share key when it becomes valid, then streams it one word per beat over a valid/ready interface: shares outer, words inner.
- Tracks whether the consumer holds a current key, and clears the captured copy when the key is revoked.

Parameters:
- NumRegsKey, 8, number of 32-bit words per key share.
- NumSharesKey, 2, number of key shares.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- key_valid_i  input  1  sideload key valid from key manager.
- key_i  input  NumSharesKey*NumRegsKey*32  key shares, packed [NumSharesKey-1:0][NumRegsKey*32-1:0]; word i of share s is key_i[s][i*32 +: 32].
- wr_valid_o  output  1  write beat valid.
- wr_ready_i  input  1  consumer accepts beat.
- wr_share_o  output  max(1,$clog2(NumSharesKey))  share index of beat.
- wr_idx_o  output  max(1,$clog2(NumRegsKey))  word index of beat.
- wr_data_o  output  32  beat data.
- key_loaded_o  output  1  consumer holds a complete current key.
- busy_o  output  1  FSM not in IDLE or LOADED.

Behaviour:
- Reset: FSM=IDLE; capture register, counters and all outputs = 0.
- Beat transfer: occurs when wr_valid_o && wr_ready_i. Once wr_valid_o is asserted, share, idx and data are held stable until the transfer. wr_valid_o never drops without a transfer.
- State IDLE:
  - If key_valid_i=1: capture key_i into the internal register, clear counters (s=0, i=0), go to LOAD.
  - Capture is registered, so the first beat appears on the cycle after key_valid_i is first sampled high.
- State LOAD:
  - wr_valid_o=1; wr_share_o=s; wr_idx_o=i; wr_data_o=cap[s][i*32 +: 32].
  - On each transfer: i increments; when i wraps from NumRegsKey-1 to 0, s increments.
  - On transfer of (NumSharesKey-1, NumRegsKey-1): go to LOADED.
  - Total beats = NumSharesKey*NumRegsKey.
  - With wr_ready_i held high, one beat per cycle.
- State LOADED:
  - wr_valid_o=0; key_loaded_o=1.
  - Changes to key_i while key_valid_i stays high are ignored; no reload occurs.
  - key_valid_i=0: clear key_loaded_o and capture register next cycle, then go to WIPE (feature on) or IDLE (feature off).
- Revocation mid-LOAD (key_valid_i=0 sampled in LOAD):
  - The in-flight beat completes at its next transfer; no further key beats are issued.
  - After that transfer, go to WIPE (feature on) or IDLE (feature off). Capture register is cleared on exit.
  - key_loaded_o stays 0.
- Re-assertion of key_valid_i during LOAD or WIPE is ignored. A new capture happens only from IDLE.
- key_loaded_o=1 only in LOADED. busy_o=1 in LOAD and WIPE.
- Counter widths: sized for the index ranges above; no arithmetic overflow beyond the wrap points.
- Asynchronous reset mid-operation: immediate return to reset values. No handshake completion is required.

Optional Feature:
- Macro: KEYMGR_SIDELOAD_WIPE_EN.
- When defined: adds state WIPE.
  - On entry, counters reset to (0,0).
  - Streams NumSharesKey*NumRegsKey beats with wr_data_o=32'h0, same order and handshake as LOAD.
  - After the last transfer, go to IDLE.
  - key_loaded_o=0 throughout.
- When not defined: no WIPE state. Revocation goes directly to IDLE and the consumer's registers are left untouched.

Test Plan:
- Basic load: key_i[s][i*32 +: 32] = 32'hA000_0000|(s<<8)|i; pulse key_valid_i high and hold; wr_ready_i=1 -> 16 consecutive beats (s,i) = (0,0)..(1,7) with matching data; key_loaded_o=1 on the cycle after beat (1,7).
- Backpressure: same key; wr_ready_i toggles 1,0,0,1,… -> each beat is held stable across ready-low cycles; no beat is skipped or duplicated; exactly 16 transfers.
- Ignore update: in LOADED, change key_i to all 32'hFFFF_FFFF with key_valid_i held high -> no beats; key_loaded_o stays 1.
- Revoke after load: drop key_valid_i in LOADED ->
  - key_loaded_o=0 next cycle.
  - With KEYMGR_SIDELOAD_WIPE_EN: 16 beats of 32'h0, then IDLE.
  - Without it: no beats, busy_o=0.
- Revoke mid-load: drop key_valid_i while beat (0,3) is stalled (wr_ready_i=0); then raise wr_ready_i -> (0,3) transfers; no key beats (0,4)+ are issued; wipe or idle per macro.
- Reset mid-LOAD: assert rst_ni=0 at beat (1,2) -> wr_valid_o, key_loaded_o and busy_o are 0 immediately; after release with key_valid_i=1, a full 16-beat load restarts at (0,0).
